// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - pixel-timing bundle between the VGA timing generator and its consumers
//
// Purpose: carries the count enable toward the timing generator and the
//          registered raster position/sync/pulse outputs away from it.
// Signals:
//   en          count enable (consumer -> generator)
//   col[9:0]    visible column, 0 outside the visible area
//   row[8:0]    visible row, 0 outside the visible area
//   visible     position is inside the visible area
//   hsync_n     horizontal sync, active-low
//   vsync_n     vertical sync, active-low
//   frame_start one-clock pulse at position (0,0)
//   line_start  one-clock pulse at column 0 of every line
// Modports: master = timing generator, slave = consumer.
interface vga_timing_if;
  logic       en;
  logic [9:0] col;
  logic [8:0] row;
  logic       visible;
  logic       hsync_n;
  logic       vsync_n;
  logic       frame_start;
  logic       line_start;

  modport master (
    input  en,
    output col, row, visible, hsync_n, vsync_n, frame_start, line_start
  );

  modport slave (
    output en,
    input  col, row, visible, hsync_n, vsync_n, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counter with registered position, sync and start pulses
//
// Purpose: walks hcount/vcount over the full raster (visible area plus
//          porches and sync) and presents a registered decode of the
//          position one clock later.
// Ports:
//   clk     pixel clock, rising edge
//   resetn  synchronous active-low reset, overrides en
//   vga     vga_timing_if.master: en in; col, row, visible, hsync_n,
//           vsync_n, frame_start, line_start out
module vga_timing #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input logic          clk,
  input logic          resetn,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // 10-bit copies so every compare below is width-matched
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
  localparam logic [9:0] HS_BEGIN   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] hcount;
  logic [9:0] vcount;

  logic h_last, v_last;
  logic h_vis, v_vis;
  logic hs_act, vs_act;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);
  assign h_vis  = (hcount < H_VIS_END);
  assign v_vis  = (vcount < V_VIS_END);
  assign hs_act = (hcount >= HS_BEGIN) && (hcount < HS_END);
  assign vs_act = (vcount >= VS_BEGIN) && (vcount < VS_END);

  // Outputs are the decode of the counter value being left behind on this
  // edge, so the outputs always trail the counters by exactly one clock and
  // stay aligned with each other.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcount          <= '0;
      vcount          <= '0;
      vga.col         <= '0;
      vga.row         <= '0;
      vga.visible     <= 1'b0;
      vga.hsync_n     <= 1'b1;
      vga.vsync_n     <= 1'b1;
      vga.frame_start <= 1'b0;
      vga.line_start  <= 1'b0;
    end else if (vga.en) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
      vga.col         <= h_vis ? hcount : '0;
      vga.row         <= v_vis ? vcount[8:0] : '0;
      vga.visible     <= h_vis && v_vis;
      vga.hsync_n     <= !hs_act;
      vga.vsync_n     <= !vs_act;
      vga.line_start  <= (hcount == '0);
      vga.frame_start <= (hcount == '0) && (vcount == '0);
    end else begin
      // Hold everything, but drop the pulses so a stall never repeats one.
      vga.frame_start <= 1'b0;
      vga.line_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing on a reduced raster
module tb_vga_timing;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic       visible;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_start;
    logic       line_start;
  } out_t;

  typedef struct {
    bit   rn;
    bit   en;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  vga_timing_if vif ();

  vga_timing #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .vga    (vif)
  );

  always #5 clk = ~clk;

  out_t q[$];
  out_t last_exp;
  int   mh = 0, mv = 0;
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0;
  int   ls_cyc = -1;

  function automatic out_t rst_val();
    out_t r;
    r.col = '0; r.row = '0; r.visible = 1'b0;
    r.hsync_n = 1'b1; r.vsync_n = 1'b1;
    r.frame_start = 1'b0; r.line_start = 1'b0;
    return r;
  endfunction

  function automatic out_t mk(input int c, input int r, input bit vis,
                              input bit hs, input bit vs, input bit fs, input bit ls);
    out_t o;
    o.col = 10'(c); o.row = 9'(r); o.visible = vis;
    o.hsync_n = hs; o.vsync_n = vs; o.frame_start = fs; o.line_start = ls;
    return o;
  endfunction

  function automatic out_t decode(input int h, input int v);
    out_t d;
    d.visible     = (h < HV) && (v < VV);
    d.col         = (h < HV) ? 10'(h) : 10'd0;
    d.row         = (v < VV) ? 9'(v) : 9'd0;
    d.hsync_n     = !((h >= HV + HF) && (h < HV + HF + HS));
    d.vsync_n     = !((v >= VV + VF) && (v < VV + VF + VS));
    d.frame_start = (h == 0) && (v == 0);
    d.line_start  = (h == 0);
    return d;
  endfunction

  task automatic model(input bit rn, input bit e, output out_t exp);
    if (!rn) begin
      exp = rst_val();
      mh = 0; mv = 0;
    end else if (e) begin
      exp = decode(mh, mv);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      exp = last_exp;
      exp.frame_start = 1'b0;
      exp.line_start = 1'b0;
    end
    last_exp = exp;
  endtask

  task automatic apply(input bit rn, input bit e, input out_t exp, input string name);
    out_t act, want;
    resetn = rn;
    vif.en = e;
    q.push_back(exp);
    @(posedge clk);
    #1;
    cyc++;
    act.col = vif.col; act.row = vif.row; act.visible = vif.visible;
    act.hsync_n = vif.hsync_n; act.vsync_n = vif.vsync_n;
    act.frame_start = vif.frame_start; act.line_start = vif.line_start;
    want = q.pop_front();
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got col=%0d row=%0d vis=%b hs=%b vs=%b fs=%b ls=%b want col=%0d row=%0d vis=%b hs=%b vs=%b fs=%b ls=%b",
               name, cyc, act.col, act.row, act.visible, act.hsync_n, act.vsync_n,
               act.frame_start, act.line_start, want.col, want.row, want.visible,
               want.hsync_n, want.vsync_n, want.frame_start, want.line_start);
    end
    if (vif.line_start === 1'b1) ls_cyc = cyc;
  endtask

  task automatic step(input bit rn, input bit e, input string name);
    out_t x;
    model(rn, e, x);
    apply(rn, e, x, name);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s timeout at cyc=%0d", name, cyc);
  endtask

  initial begin
    vec_t tbl[9];
    out_t dummy;
    int guard;
    int last_fs, last_ls, hs_fall, vs_fall, fs_seen, maxc, maxr, t0;
    bit prev_hs, prev_vs;

    vif.en = 1'b0;

    // reset, first positions after release, a one-clock stall, and a re-reset
    tbl[0] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
    tbl[1] = '{1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0, 0)};
    tbl[2] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1)};
    tbl[3] = '{1'b1, 1'b1, mk(1, 0, 1, 1, 1, 0, 0)};
    tbl[4] = '{1'b1, 1'b0, mk(1, 0, 1, 1, 1, 0, 0)};
    tbl[5] = '{1'b1, 1'b1, mk(2, 0, 1, 1, 1, 0, 0)};
    tbl[6] = '{1'b1, 1'b1, mk(3, 0, 1, 1, 1, 0, 0)};
    tbl[7] = '{1'b0, 1'b1, mk(0, 0, 0, 1, 1, 0, 0)};
    tbl[8] = '{1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1)};

    for (int i = 0; i < 9; i++) begin
      model(tbl[i].rn, tbl[i].en, dummy);
      apply(tbl[i].rn, tbl[i].en, tbl[i].exp, "table");
    end

    // two free-running frames with period, sync width and range checks
    last_fs = -1; last_ls = -1; hs_fall = -1; vs_fall = -1;
    fs_seen = 0; maxc = 0; maxr = 0; prev_hs = 1'b1; prev_vs = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b1, 1'b1, "run");
      if (vif.line_start) begin
        if (last_ls >= 0) check("line_period", cyc - last_ls, HT);
        last_ls = cyc;
      end
      if (vif.frame_start) begin
        if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
        last_fs = cyc;
        fs_seen++;
      end
      if (prev_hs && !vif.hsync_n) begin
        hs_fall = cyc;
        if (last_ls >= 0) check("hsync_offset", cyc - last_ls, HV + HF);
      end
      if (!prev_hs && vif.hsync_n && hs_fall >= 0) check("hsync_width", cyc - hs_fall, HS);
      if (prev_vs && !vif.vsync_n) begin
        vs_fall = cyc;
        if (last_fs >= 0) check("vsync_offset", cyc - last_fs, (VV + VF) * HT);
      end
      if (!prev_vs && vif.vsync_n && vs_fall >= 0) check("vsync_width", cyc - vs_fall, VS * HT);
      prev_hs = vif.hsync_n;
      prev_vs = vif.vsync_n;
      if (int'(vif.col) > maxc) maxc = int'(vif.col);
      if (int'(vif.row) > maxr) maxr = int'(vif.row);
    end
    check("frame_count", fs_seen, 2);
    check("col_max", maxc, HV - 1);
    check("row_max", maxr, VV - 1);

    // stall for 10 clocks in the back porch
    guard = 0;
    while (mh != 28 && guard < FRAME) begin
      step(1'b1, 1'b1, "to_pause");
      guard++;
    end
    if (guard >= FRAME) timeout("to_pause");
    t0 = ls_cyc;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "paused");
    guard = 0;
    do begin
      step(1'b1, 1'b1, "resume");
      guard++;
    end while (!vif.line_start && guard < 2 * HT);
    if (guard >= 2 * HT) timeout("resume");
    else check("paused_line_len", ls_cyc - t0, HT + 10);

    // one-clock reset mid-frame at line 7, column 10
    guard = 0;
    while (!(mh == 10 && mv == 7) && guard < 2 * FRAME) begin
      step(1'b1, 1'b1, "to_reset");
      guard++;
    end
    if (guard >= 2 * FRAME) timeout("to_reset");
    step(1'b0, 1'b1, "mid_reset");
    check("mid_reset_vis", int'(vif.visible), 0);
    step(1'b1, 1'b1, "after_reset");
    check("after_reset_fs", int'(vif.frame_start), 1);

    // terminal position wraps to (0,0)
    guard = 0;
    while (!(mh == HT - 1 && mv == VT - 1) && guard < 2 * FRAME) begin
      step(1'b1, 1'b1, "to_terminal");
      guard++;
    end
    if (guard >= 2 * FRAME) timeout("to_terminal");
    step(1'b1, 1'b1, "terminal");
    check("terminal_fs", int'(vif.frame_start), 0);
    step(1'b1, 1'b1, "wrap");
    check("wrap_fs", int'(vif.frame_start), 1);
    check("wrap_col", int'(vif.col), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_VIS, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, default 96: horizontal sync width, in clocks.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in clocks.
REQ-005 Parameter V_VIS, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 clk  input  1  pixel clock; all state updates on its rising edge.
REQ-010 resetn  input  1  reset; synchronous, active-low.
REQ-011 en  input  1  count enable; when low, all state and outputs hold.
REQ-012 col  output  10  current visible column, consumed by the border/sprite stages.
REQ-013 row  output  9  current visible row.
REQ-014 visible  output  1  high when the current position is inside the visible area.
REQ-015 hsync_n  output  1  horizontal sync, active-low.
REQ-016 vsync_n  output  1  vertical sync, active-low.
REQ-017 frame_start  output  1  one-clock pulse at position (0,0).
REQ-018 line_start  output  1  one-clock pulse at column 0 of every line, blanking lines included.

Function
REQ-019 Internal hcount (10 bit) SHALL count 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800), incrementing once per enabled clock.
REQ-020 At hcount = H_TOTAL-1, hcount SHALL wrap to 0 on the next enabled clock and vcount SHALL advance in the same cycle.
REQ-021 Internal vcount (10 bit) SHALL count 0..V_TOTAL-1, where V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525); when hcount and vcount are both at terminal values, both SHALL wrap to 0 together.
REQ-022 All outputs SHALL be registered and SHALL reflect the counter position of the previous clock (latency 1); all outputs SHALL be mutually aligned.
REQ-023 visible SHALL = (hcount < H_VIS) AND (vcount < V_VIS).
REQ-024 col SHALL = hcount when hcount < H_VIS, else 0; row SHALL = vcount[8:0] when vcount < V_VIS, else 0.
REQ-025 hsync_n SHALL be low iff H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC (656..751).
REQ-026 vsync_n SHALL be low iff V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC (490..491), for whole lines.
REQ-027 frame_start SHALL be high for exactly one clock per frame, when hcount=0 and vcount=0; line_start SHALL be high when hcount=0.
REQ-028 With en low, counters and all output registers SHALL hold; pulses (frame_start, line_start) SHALL be forced to 0 while en is low so that no pulse is repeated.
REQ-029 Counters SHALL never exceed their terminal values; no out-of-range state is reachable.

Reset
REQ-030 While resetn is low at a clock edge: hcount=0, vcount=0, col=0, row=0, visible=0, hsync_n=1, vsync_n=1, frame_start=0, line_start=0.
REQ-031 Reset SHALL take priority over en.
REQ-032 Reset asserted mid-frame SHALL restart at (0,0) with no partial sync pulse carried over.
REQ-033 On the first clock after resetn rises with en high, the outputs SHALL show position (0,0): visible=1, frame_start=1, line_start=1.

Verification
REQ-034 Release reset, en=1 -> frame_start repeats every 420000 clocks; line_start repeats every 800 clocks.
REQ-035 Line scan -> col runs 0..639 with visible=1, then 0 with visible=0 for 160 clocks; hsync_n is low for exactly 96 clocks, starting 656 clocks after line_start.
REQ-036 Frame scan -> row runs 0..479; vsync_n is low for exactly 1600 clocks, starting at line 490 column 0.
REQ-037 en=0 for 10 clocks at hcount=700 -> all outputs frozen, no pulse; after resume the line completes at the same total count plus 10.
REQ-038 resetn=0 for 1 clock at line 300, column 200 -> next outputs match the reset values, then (0,0) with frame_start=1.
REQ-039 Terminal position (799,524) -> next position (0,0) with frame_start=1; row and col never exceed 479 and 639.
